// File: rtl/sum_seq_pkg.sv
// Shared types and default sizing for the sequential add/sub controller.
package sum_seq_pkg;
  localparam int NB_DEF = 4;
  localparam int NW_DEF = 4;
  localparam int W_DEF  = NB_DEF * NW_DEF;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/sum_seq_ctrl_if.sv
// Requester-side handshake and operand/result bus for sum_seq_ctrl.
interface sum_seq_ctrl_if import sum_seq_pkg::*; #(parameter int W = W_DEF);
  logic         start;
  logic         op_sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Co;
  logic         ovf;

  modport master (output start, op_sub, A, B, input busy, done, S, Co, ovf);
  modport slave  (input start, op_sub, A, B, output busy, done, S, Co, ovf);
endinterface

// File: rtl/add_slice.sv
// Combinational NB-bit ripple-carry adder built from chained full-adder cells.
module add_slice #(
  parameter int NB = 4
) (
  input  logic [NB-1:0] A,
  input  logic [NB-1:0] B,
  input  logic          Ci,
  output logic [NB-1:0] S,
  output logic          Cout
);
  logic [NB:0] w_c;

  assign w_c[0] = Ci;
  assign Cout   = w_c[NB];

  for (genvar g = 0; g < NB; g++) begin : g_bit
    fa_cell u_fa (
      .a  (A[g]),
      .b  (B[g]),
      .ci (w_c[g]),
      .s  (S[g]),
      .co (w_c[g+1])
    );
  end
endmodule

// File: rtl/fa_cell.sv
// 1-bit full adder cell, the building block of the ripple slice.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/sum_seq_ctrl.sv
// Sequential W-bit add/sub: one NB-bit slice per clock, LSB slice first,
// carry held in a register between slices.
module sum_seq_ctrl import sum_seq_pkg::*; #(
  parameter int NB = NB_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sum_seq_ctrl_if.slave bus
);
  localparam int W  = NB * NW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_s;
  logic          r_sub;
  logic          r_carry;
  logic          r_co;
  logic          r_ovf;
  logic          r_busy;
  logic          r_done;
  logic [IW-1:0] r_idx;

  logic [NB-1:0] w_a_sl;
  logic [NB-1:0] w_b_sl;
  logic [NB-1:0] w_sum;
  logic          w_cout;
  logic          w_last;
  logic          w_ovf;

  assign w_last = (r_idx == IW'(NW - 1));
  assign w_a_sl = r_a[r_idx*NB +: NB];
  assign w_b_sl = r_b[r_idx*NB +: NB] ^ {NB{r_sub}};

  // Only meaningful on the MSB slice; latched solely when w_last is set.
  assign w_ovf = (r_a[W-1] == (r_b[W-1] ^ r_sub)) & (w_sum[NB-1] != r_a[W-1]);

  add_slice #(.NB(NB)) u_slice (
    .A    (w_a_sl),
    .B    (w_b_sl),
    .Ci   (r_carry),
    .S    (w_sum),
    .Cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_sub   <= bus.op_sub;
            r_carry <= bus.op_sub;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_s[r_idx*NB +: NB] <= w_sum;
          r_carry             <= w_cout;
          if (w_last) begin
            r_co    <= w_cout;
            r_ovf   <= w_ovf;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.S    = r_s;
  assign bus.Co   = r_co;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Self-checking bench for sum_seq_ctrl (NB=4, NW=4, W=16) against an integer reference model.
module tb_sum_seq_ctrl;
  localparam int NB = 4;
  localparam int NW = 4;
  localparam int W  = NB * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  sum_seq_ctrl_if #(.W(W)) bus ();

  sum_seq_ctrl #(.NB(NB), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, modulo 2^16 result, unsigned carry, signed range overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] s, output logic co, output logic ov);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    ur = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    s  = W'(ur);
    co = sub ? (ua >= ub) : (ur > 65535);
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with timeline checks; inputs are scrambled after the start edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input string nm);
    logic [W-1:0] es;
    logic eco, eov;
    model(a, b, sub, es, eco, eov);
    bus.A = a; bus.B = b; bus.op_sub = sub; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom); bus.op_sub = 1'($urandom);
    for (int k = 0; k < NW; k++) begin
      n_vec++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy_phase k=%0d: got busy=%b done=%b, want busy=1 done=0", nm, k, bus.busy, bus.done);
      end
      tick();
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.S !== es || bus.Co !== eco || bus.ovf !== eov) begin
      n_err++;
      $display("FAIL %s result: got done=%b busy=%b S=%h Co=%b ovf=%b, want done=1 busy=0 S=%h Co=%b ovf=%b",
               nm, bus.done, bus.busy, bus.S, bus.Co, bus.ovf, es, eco, eov);
    end
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.S !== es || bus.Co !== eco || bus.ovf !== eov) begin
      n_err++;
      $display("FAIL %s post_done: got done=%b busy=%b S=%h Co=%b ovf=%b, want done=0 busy=0 S=%h Co=%b ovf=%b",
               nm, bus.done, bus.busy, bus.S, bus.Co, bus.ovf, es, eco, eov);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.op_sub = 1'b0;
    tick();
    tick();
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.S !== '0 || bus.Co !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b S=%h Co=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.S, bus.Co, bus.ovf);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000};
    logic [W-1:0] tb [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
    logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) run_op(ta[i], tb[i], ts[i], $sformatf("directed%0d", i));
  endtask

  task automatic test_ignore_start();
    bus.A = 16'h0001; bus.B = 16'h0001; bus.op_sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.A = 16'h1111;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b1 || bus.S !== 16'h0002) begin
      n_err++;
      $display("FAIL ignore_start: got done=%b S=%h, want done=1 S=0002", bus.done, bus.S);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.S !== 16'h0002) begin
        n_err++;
        $display("FAIL ignore_start_quiet c=%0d: got done=%b busy=%b S=%h, want 0/0/0002", c, bus.done, bus.busy, bus.S);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.A = 16'hAAAA; bus.B = 16'h5555; bus.op_sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.S !== '0 || bus.Co !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b S=%h Co=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.S, bus.Co, bus.ovf);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_nodone c=%0d: got done=%b busy=%b, want 0/0", c, bus.done, bus.busy);
      end
    end
    run_op(16'h0003, 16'h0004, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] es;
    logic eco, eov;
    bit seen;
    model(16'hC357, 16'h2468, 1'b1, es, eco, eov);
    bus.A = 16'hC357; bus.B = 16'h2468; bus.op_sub = 1'b1; bus.start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL b2b_first_done: got no done within 20 cycles, want one");
    end
    for (int p = 0; p < 3; p++) begin
      for (int c = 1; c <= NW + 2; c++) begin
        tick();
        n_vec++;
        if (bus.done !== (c == NW + 2) || bus.S !== es || bus.Co !== eco || bus.ovf !== eov) begin
          n_err++;
          $display("FAIL b2b p=%0d c=%0d: got done=%b S=%h Co=%b ovf=%b, want done=%b S=%h Co=%b ovf=%b",
                   p, c, bus.done, bus.S, bus.Co, bus.ovf, (c == NW + 2), es, eco, eov);
        end
      end
    end
    bus.start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
  endtask

  initial begin
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.A = '0; bus.B = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
